// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - round-robin N-channel front end for the UDP send interface
//
// Purpose: arbitrates per-channel send requests in the rgmii_clk domain, latches the
// winning payload/length and runs the valid/ready handshake with the UDP core. Adds
// timeout abort, zero-length rejection and per-channel stretched done pulses.
//
// Ports:
//   rgmii_clk            in   clock
//   rstn                 in   async active-low reset
//   ch_valid             in   [N_CH]      per-channel request level, held until ch_done
//   ch_data              in   [N_CH*DW]   payloads, channel i at [i*DW +: DW]
//   ch_length            in   [N_CH*16]   byte lengths, channel i at [i*16 +: 16]
//   ch_done              out  [N_CH]      1-cycle pulse: accepted, aborted or rejected
//   done_stretch         out  [N_CH]      ch_done stretched to STRETCH cycles
//   udp_send_data_valid  out  request to UDP core
//   udp_send_data_ready  in   accept from UDP core
//   udp_send_data        out  [DW]        latched payload
//   udp_send_data_length out  [16]        latched, clipped length
//   err_timeout          out  1-cycle pulse on abort
//   err_len              out  1-cycle pulse on zero-length reject
//   abort_cnt            out  [8]         saturating abort counter
module udp_tx_arbiter #(
    parameter int N_CH       = 2,
    parameter int UDP_LENGTH = 960,
    parameter int STRETCH    = 16,
    parameter int GAP        = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                           rgmii_clk,
    input  logic                           rstn,
    input  logic [N_CH-1:0]                ch_valid,
    input  logic [N_CH*UDP_LENGTH*8-1:0]   ch_data,
    input  logic [N_CH*16-1:0]             ch_length,
    output logic [N_CH-1:0]                ch_done,
    output logic [N_CH-1:0]                done_stretch,
    output logic                           udp_send_data_valid,
    input  logic                           udp_send_data_ready,
    output logic [UDP_LENGTH*8-1:0]        udp_send_data,
    output logic [15:0]                    udp_send_data_length,
    output logic                           err_timeout,
    output logic                           err_len,
    output logic [7:0]                     abort_cnt
);

    localparam int DW = UDP_LENGTH * 8;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;
    localparam int SW = $clog2(STRETCH + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [15:0]   LEN_MAX = 16'(UDP_LENGTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAPW = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   rr_q, gsel_q, grant_idx, off;
    logic [CW:0]     sum;
    logic            grant_any;
    logic [N_CH-1:0] rot;
    logic [15:0]     sel_len;
    logic [DW-1:0]   sel_data;
    logic [TW-1:0]   timer_q;
    logic [GW-1:0]   gap_q;
    logic            gap_done;
    logic            load, reject, accept, abort;
    logic [N_CH-1:0] done_d;
    logic [SW-1:0]   scnt_q [N_CH];

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        logic [CW:0] t;
        t = {1'b0, v} + (CW+1)'(1);
        if (t >= (CW+1)'(N_CH)) t = '0;
        return t[CW-1:0];
    endfunction

    // Requests rotated so that bit k is channel (rr + k) mod N_CH; the lowest set
    // bit is then the first requester at or after the round-robin pointer.
    always_comb begin
        rot = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (rr_q == CW'(j)) begin
                for (int k = 0; k < N_CH; k++) begin
                    rot[k] = ch_valid[(j + k) % N_CH];
                end
            end
        end
    end

    always_comb begin
        grant_any = |rot;
        off = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) off = CW'(k);
        end
        sum = {1'b0, rr_q} + {1'b0, off};
        if (sum >= (CW+1)'(N_CH)) sum = sum - (CW+1)'(N_CH);
        grant_idx = sum[CW-1:0];
    end

    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_idx == CW'(k)) begin
                sel_len  = ch_length[k*16 +: 16];
                sel_data = ch_data[k*DW +: DW];
            end
        end
    end

    // GAP of 0 or 1 both spend exactly one cycle in GAPW.
    assign gap_done = (GAP <= 1) || (gap_q == G_LAST);

    // FSM: state register
    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_any) state_d = (sel_len == 16'd0) ? GAPW : SEND;
            SEND: if (udp_send_data_ready || timer_q == T_LAST) state_d = GAPW;
            GAPW: if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: output strobes (registered below, so every pulse lands one cycle later)
    always_comb begin
        load   = (state_q == IDLE) && grant_any && (sel_len != 16'd0);
        reject = (state_q == IDLE) && grant_any && (sel_len == 16'd0);
        accept = (state_q == SEND) && udp_send_data_ready;
        abort  = (state_q == SEND) && !udp_send_data_ready && (timer_q == T_LAST);
        done_d = '0;
        if (reject)          done_d = N_CH'(1) << grant_idx;
        if (accept || abort) done_d = N_CH'(1) << gsel_q;
    end

    // Valid follows the state register directly so an async reset drops it at once.
    assign udp_send_data_valid = (state_q == SEND);

    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            rr_q                 <= '0;
            gsel_q               <= '0;
            udp_send_data        <= '0;
            udp_send_data_length <= '0;
            timer_q              <= '0;
            gap_q                <= '0;
            ch_done              <= '0;
            err_len              <= 1'b0;
            err_timeout          <= 1'b0;
            abort_cnt            <= '0;
        end else begin
            // The pointer can advance at grant time: no other grant happens until
            // this transfer finishes, so the effect equals advancing at completion.
            if (state_q == IDLE && grant_any) begin
                rr_q   <= wrap_inc(grant_idx);
                gsel_q <= grant_idx;
            end
            if (load) begin
                udp_send_data        <= sel_data;
                udp_send_data_length <= (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
            end
            timer_q     <= (state_q == SEND) ? timer_q + 1'b1 : '0;
            gap_q       <= (state_q == GAPW) ? gap_q + 1'b1 : '0;
            ch_done     <= done_d;
            err_len     <= reject;
            err_timeout <= abort;
            if (abort && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
        end
    end

    // Done stretchers: reloaded on every done so overlapping pulses merge.
    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_CH; i++) scnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (done_d[i])             scnt_q[i] <= SW'(STRETCH);
                else if (scnt_q[i] != '0)  scnt_q[i] <= scnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        done_stretch = '0;
        for (int i = 0; i < N_CH; i++) done_stretch[i] = (scnt_q[i] != '0);
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - directed self-checking bench for udp_tx_arbiter
module tb_udp_tx_arbiter;

    localparam int N_CH       = 2;
    localparam int UDP_LENGTH = 960;
    localparam int DW         = UDP_LENGTH * 8;
    localparam int STRETCH    = 16;
    localparam int GAP        = 4;
    localparam int TIMEOUT    = 10;

    logic                 rgmii_clk = 1'b0;
    logic                 rstn;
    logic [N_CH-1:0]      ch_valid;
    logic [N_CH*DW-1:0]   ch_data;
    logic [N_CH*16-1:0]   ch_length;
    logic [N_CH-1:0]      ch_done;
    logic [N_CH-1:0]      done_stretch;
    logic                 udp_send_data_valid;
    logic                 udp_send_data_ready;
    logic [DW-1:0]        udp_send_data;
    logic [15:0]          udp_send_data_length;
    logic                 err_timeout;
    logic                 err_len;
    logic [7:0]           abort_cnt;

    udp_tx_arbiter #(
        .N_CH(N_CH), .UDP_LENGTH(UDP_LENGTH), .STRETCH(STRETCH), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .rgmii_clk(rgmii_clk), .rstn(rstn), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_length(ch_length), .ch_done(ch_done), .done_stretch(done_stretch),
        .udp_send_data_valid(udp_send_data_valid), .udp_send_data_ready(udp_send_data_ready),
        .udp_send_data(udp_send_data), .udp_send_data_length(udp_send_data_length),
        .err_timeout(err_timeout), .err_len(err_len), .abort_cnt(abort_cnt)
    );

    always #5 rgmii_clk = ~rgmii_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_d0, exp_d1;
    int cyc, vcur, vrun_last, gcur, gap_last, vtotal;
    int done_cnt [N_CH];
    int done_cyc_last, done_cyc_prev;
    int err_len_cnt, err_to_cnt, wide_done;
    int scur, srun_last;
    int ready_after;
    logic [N_CH-1:0] hold, prev_done;
    logic [15:0] last_len;
    logic [DW-1:0] last_data;
    int grants [$];

    task automatic mon_clear();
        cyc = 0; vcur = 0; vrun_last = 0; gcur = 0; gap_last = 0; vtotal = 0;
        for (int i = 0; i < N_CH; i++) done_cnt[i] = 0;
        done_cyc_last = 0; done_cyc_prev = 0;
        err_len_cnt = 0; err_to_cnt = 0; wide_done = 0;
        scur = 0; srun_last = 0; ready_after = 0;
        hold = '0; prev_done = '0; last_len = '0; last_data = '0;
        grants.delete();
    endtask

    // Advance one cycle, sample at the falling edge, act as requesters and UDP core.
    task automatic step();
        @(negedge rgmii_clk);
        cyc++;
        if (udp_send_data_valid) begin
            if (vcur == 0) gap_last = gcur;
            vcur++; vtotal++; gcur = 0;
            last_len  = udp_send_data_length;
            last_data = udp_send_data;
        end else begin
            if (vcur != 0) vrun_last = vcur;
            vcur = 0; gcur++;
        end
        udp_send_data_ready = (ready_after > 0) && udp_send_data_valid && (vcur >= ready_after);
        for (int i = 0; i < N_CH; i++) begin
            if (ch_done[i]) begin
                done_cnt[i]++;
                grants.push_back(i);
                if (i == 0) begin done_cyc_prev = done_cyc_last; done_cyc_last = cyc; end
                if (!hold[i]) ch_valid[i] = 1'b0;
            end
        end
        if ((ch_done & prev_done) != '0) wide_done++;
        prev_done = ch_done;
        if (err_len) err_len_cnt++;
        if (err_timeout) err_to_cnt++;
        if (done_stretch[0]) scur++;
        else begin
            if (scur != 0) srun_last = scur;
            scur = 0;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; ch_valid = '0; udp_send_data_ready = 1'b0;
        repeat (2) @(negedge rgmii_clk);
        rstn = 1'b1;
        mon_clear();
    endtask

    task automatic test_reset();
        rstn = 1'b0; ch_valid = '0; udp_send_data_ready = 1'b0;
        repeat (2) @(negedge rgmii_clk);
        checks++;
        if (udp_send_data_valid !== 1'b0 || ch_done !== '0 || done_stretch !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b done=%b stretch=%b expected 0", udp_send_data_valid, ch_done, done_stretch);
        end
        checks++;
        if (udp_send_data_length !== 16'd0 || udp_send_data !== '0 || abort_cnt !== 8'd0 || err_len !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: len=%0d data[31:0]=%h abort=%0d elen=%b eto=%b expected 0", udp_send_data_length, udp_send_data[31:0], abort_cnt, err_len, err_timeout);
        end
        rstn = 1'b1;
        mon_clear();
    endtask

    task automatic test_single();
        do_reset();
        ch_length = {16'd0, 16'd100};
        ready_after = 5;
        ch_valid = 2'b01;
        step();
        checks++;
        if (udp_send_data_valid !== 1'b1) begin
            errors++; $display("FAIL latency: valid=%b expected 1 one cycle after request", udp_send_data_valid);
        end
        checks++;
        if (udp_send_data_length !== 16'd100 || udp_send_data !== exp_d0) begin
            errors++; $display("FAIL single_payload: len=%0d data[31:0]=%h expected 100 %h", udp_send_data_length, udp_send_data[31:0], exp_d0[31:0]);
        end
        for (int n = 0; n < 40 && done_cnt[0] == 0; n++) step();
        checks++;
        if (done_cnt[0] != 1) begin
            errors++; $display("FAIL single_done: ch_done[0] pulses=%0d expected 1", done_cnt[0]);
        end
        checks++;
        if (vrun_last != 5) begin
            errors++; $display("FAIL single_valid_len: valid high %0d cycles expected 5", vrun_last);
        end
        for (int n = 0; n < 40 && srun_last == 0; n++) step();
        checks++;
        if (srun_last != STRETCH) begin
            errors++; $display("FAIL single_stretch: done_stretch[0] high %0d cycles expected %0d", srun_last, STRETCH);
        end
        checks++;
        if (wide_done != 0 || done_cnt[0] != 1 || err_len_cnt != 0 || err_to_cnt != 0) begin
            errors++; $display("FAIL single_pulses: wide=%0d done=%0d elen=%0d eto=%0d expected 0 1 0 0", wide_done, done_cnt[0], err_len_cnt, err_to_cnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ch_length = {16'd20, 16'd10};
        hold = 2'b11;
        ready_after = 1;
        ch_valid = 2'b11;
        for (int n = 0; n < 200 && grants.size() < 4; n++) step();
        hold = '0; ch_valid = '0;
        checks++;
        if (grants.size() < 4) begin
            errors++; $display("FAIL rr_count: %0d grants expected 4", grants.size());
        end else if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
            errors++; $display("FAIL rr_order: %0d %0d %0d %0d expected 0 1 0 1", grants[0], grants[1], grants[2], grants[3]);
        end
        checks++;
        if (gap_last != GAP + 1) begin
            errors++; $display("FAIL rr_gap: %0d idle cycles expected %0d", gap_last, GAP + 1);
        end
        checks++;
        if (last_len !== 16'd20 || last_data !== exp_d1) begin
            errors++; $display("FAIL rr_payload: len=%0d data[31:0]=%h expected 20 %h", last_len, last_data[31:0], exp_d1[31:0]);
        end
        repeat (8) step();
    endtask

    task automatic test_length();
        logic [15:0] req [4];
        logic [15:0] exp [4];
        int vt;
        req = '{16'd2000, 16'd961, 16'd960, 16'd1};
        exp = '{16'd960,  16'd960, 16'd960, 16'd1};
        do_reset();
        ready_after = 1;
        for (int t = 0; t < 4; t++) begin
            ch_length = {16'd0, req[t]};
            ch_valid = 2'b01;
            for (int n = 0; n < 40 && done_cnt[0] == t; n++) step();
            checks++;
            if (done_cnt[0] != t + 1 || last_len !== exp[t]) begin
                errors++; $display("FAIL clip_%0d: done=%0d len=%0d expected %0d %0d", req[t], done_cnt[0], last_len, t + 1, exp[t]);
            end
        end
        vt = vtotal;
        ch_length = {16'd0, 16'd0};
        ch_valid = 2'b10;
        for (int n = 0; n < 40 && done_cnt[1] == 0; n++) step();
        repeat (10) step();
        checks++;
        if (err_len_cnt != 1 || done_cnt[1] != 1 || vtotal != vt) begin
            errors++; $display("FAIL zero_len: err_len=%0d done1=%0d valid_cycles=%0d expected 1 1 0", err_len_cnt, done_cnt[1], vtotal - vt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ch_length = {16'd0, 16'd64};
        hold = 2'b01;
        ch_valid = 2'b01;
        for (int n = 0; n < 50 && err_to_cnt == 0; n++) step();
        checks++;
        if (vrun_last != TIMEOUT || abort_cnt !== 8'd1 || done_cnt[0] != 1 || err_to_cnt != 1) begin
            errors++; $display("FAIL timeout_first: valid=%0d abort=%0d done=%0d eto=%0d expected %0d 1 1 1", vrun_last, abort_cnt, done_cnt[0], err_to_cnt, TIMEOUT);
        end
        step();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: err_timeout=%b expected 0 one cycle later", err_timeout);
        end
        for (int n = 0; n < 8000 && err_to_cnt < 300; n++) step();
        checks++;
        if (err_to_cnt != 300 || abort_cnt !== 8'd255) begin
            errors++; $display("FAIL timeout_sat: aborts=%0d abort_cnt=%0d expected 300 255", err_to_cnt, abort_cnt);
        end
        hold = '0;
        ch_valid = '0;
        repeat (2) step();
    endtask

    task automatic test_reset_mid_send();
        mon_clear();
        ch_length = {16'd0, 16'd50};
        ch_valid = 2'b01;
        for (int n = 0; n < 40 && vcur < 3; n++) step();
        checks++;
        if (vcur < 3) begin
            errors++; $display("FAIL rst_setup: valid run %0d expected >= 3", vcur);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (udp_send_data_valid !== 1'b0 || ch_done !== '0 || done_stretch !== '0 || abort_cnt !== 8'd0 || udp_send_data_length !== 16'd0) begin
            errors++; $display("FAIL rst_async: valid=%b done=%b stretch=%b abort=%0d len=%0d expected 0", udp_send_data_valid, ch_done, done_stretch, abort_cnt, udp_send_data_length);
        end
        @(negedge rgmii_clk);
        rstn = 1'b1;
        mon_clear();
        ready_after = 2;
        step();
        checks++;
        if (udp_send_data_valid !== 1'b1 || done_cnt[0] != 0) begin
            errors++; $display("FAIL rst_regrant: valid=%b done=%0d expected 1 0", udp_send_data_valid, done_cnt[0]);
        end
        for (int n = 0; n < 40 && done_cnt[0] == 0; n++) step();
        checks++;
        if (done_cnt[0] != 1 || vrun_last != 2) begin
            errors++; $display("FAIL rst_complete: done=%0d valid=%0d expected 1 2", done_cnt[0], vrun_last);
        end
    endtask

    task automatic test_stretch_retrigger();
        do_reset();
        ch_length = {16'd0, 16'd30};
        hold = 2'b01;
        ready_after = 3;
        ch_valid = 2'b01;
        for (int n = 0; n < 100 && done_cnt[0] < 2; n++) step();
        hold = '0;
        ch_valid = '0;
        checks++;
        if (done_cnt[0] != 2 || done_cyc_last - done_cyc_prev != 8) begin
            errors++; $display("FAIL retrig_spacing: dones=%0d spacing=%0d expected 2 8", done_cnt[0], done_cyc_last - done_cyc_prev);
        end
        for (int n = 0; n < 60 && srun_last == 0; n++) step();
        checks++;
        if (srun_last != 8 + STRETCH) begin
            errors++; $display("FAIL retrig_stretch: high %0d cycles expected %0d", srun_last, 8 + STRETCH);
        end
    endtask

    initial begin
        rstn = 1'b0;
        ch_valid = '0;
        udp_send_data_ready = 1'b0;
        exp_d0 = {240{32'hC0DE0000}};
        exp_d1 = {240{32'hBEEF0001}};
        ch_data = {exp_d1, exp_d0};
        ch_length = '0;
        mon_clear();
        test_reset();
        test_single();
        test_round_robin();
        test_length();
        test_timeout();
        test_reset_mid_send();
        test_stretch_retrigger();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
